// File: rtl/sim_monitor_pkg.sv
// ============================================================================
// Module : sim_monitor_pkg
// Brief  : Shared types and default constants for the simulation monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sim_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PASSED = 2'd1,
        ST_FAILED = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } log_entry_t;

    localparam int unsigned DEF_DONE_ADDR = 212;
    localparam int unsigned DEF_PASS_DATA = 511;
    localparam int unsigned DEF_TIMEOUT   = 500;
    localparam int unsigned CYCLE_W       = 16;

endpackage

`default_nettype wire

// File: rtl/mon_fifo.sv
// ============================================================================
// Module : mon_fifo
// Brief  : Store-log FIFO with pointer-MSB full/empty and a sticky drop flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mon_fifo
    import sim_monitor_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter type entry_t = log_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop_ready,
    output logic   pop_valid,
    output entry_t pop_data,
    output logic   overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        do_pop;
    logic        do_push;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = !empty && pop_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push   = push && (!full || do_pop);
    assign pop_valid = !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_comb begin
        pop_data = '0;
        if (!empty) pop_data = mem[rd_ptr[AW-1:0]];
    end

endmodule

`default_nettype wire

// File: rtl/sim_monitor.sv
// ============================================================================
// Module : sim_monitor
// Brief  : Watches processor stores for a done/pass marker, enforces a cycle
//          budget and optionally logs stores (macro SIM_MONITOR_LOG_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sim_monitor
    import sim_monitor_pkg::*;
#(
    parameter int unsigned DONE_ADDR = DEF_DONE_ADDR,
    parameter int unsigned PASS_DATA = DEF_PASS_DATA,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    parameter int unsigned LOG_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemWriteM,
    input  logic [31:0]         ALUResultM,
    input  logic [31:0]         WriteDataM,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic                timed_out,
    output logic [CYCLE_W-1:0]  cycle_count,
    output logic                log_valid,
    input  logic                log_ready,
    output logic [31:0]         log_addr,
    output logic [31:0]         log_data,
    output logic                log_overflow
);

    state_t state;
    logic   in_run;
    logic   deciding;
    logic   budget_spent;

    assign in_run       = (state == ST_RUN);
    assign deciding     = MemWriteM && (ALUResultM == DONE_ADDR);
    assign budget_spent = (cycle_count == CYCLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
        end else if (in_run) begin
            if (cycle_count != {CYCLE_W{1'b1}}) cycle_count <= cycle_count + CYCLE_W'(1);
            // The store has priority over the budget when both land on one edge.
            if (deciding) begin
                done <= 1'b1;
                if (WriteDataM == PASS_DATA) begin
                    state <= ST_PASSED;
                    pass  <= 1'b1;
                end else begin
                    state <= ST_FAILED;
                    fail  <= 1'b1;
                end
            end else if (budget_spent) begin
                state     <= ST_FAILED;
                done      <= 1'b1;
                fail      <= 1'b1;
                timed_out <= 1'b1;
            end
        end
    end

`ifdef SIM_MONITOR_LOG_EN
    log_entry_t push_entry;
    log_entry_t head_entry;
    logic       log_push;

    assign log_push        = in_run && MemWriteM;
    assign push_entry.addr = ALUResultM;
    assign push_entry.data = WriteDataM;

    mon_fifo #(
        .DEPTH   (LOG_DEPTH),
        .entry_t (log_entry_t)
    ) u_log_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (log_push),
        .push_data (push_entry),
        .pop_ready (log_ready),
        .pop_valid (log_valid),
        .pop_data  (head_entry),
        .overflow  (log_overflow)
    );

    assign log_addr = head_entry.addr;
    assign log_data = head_entry.data;
`else
    localparam int unsigned unused_log_depth = LOG_DEPTH;
    logic unused_log_ready;

    assign unused_log_ready = log_ready;
    assign log_valid        = 1'b0;
    assign log_addr         = '0;
    assign log_data         = '0;
    assign log_overflow     = 1'b0;
`endif

endmodule

`default_nettype wire
